// File: rtl/xillybus_rd_framer.sv
// -----------------------------------------------------------------------------
// xillybus_rd_framer
//
// Sits directly in front of the Xillybus 32-bit host-read stream. User logic
// delivers payload words on a valid/ready stream. Each packet is wrapped as
//   header  {16'hCE7C, seq[15:0]}
//   payload words (at most MAX_LEN per frame)
//   trailer {8'hEE, 7'b0, trunc, cnt[15:0]}
// and the words are queued in an internal FIFO that feeds the user_r_* port.
//
// While the host has the device file closed (user_r_open=0), the FIFO is
// flushed, the frame being built is abandoned, and every offered input word is
// accepted, thrown away and counted in drop_cnt.
//
// Handshakes:
//   s_*      : a word moves on a clock edge where s_valid && s_ready are both
//              high. s_ready never depends on s_valid in the same cycle.
//   user_r_* : Xillybus read semantics. A read happens on an edge where
//              user_r_rden=1 and user_r_empty=0. user_r_data holds that word
//              from the following cycle until the next read. rden while empty
//              is ignored.
//
// Ports:
//   bus_clk       sole clock
//   rst_b         asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last   payload input stream
//   user_r_rden/user_r_empty/user_r_data/user_r_open   Xillybus read port
//   drop_cnt      words discarded while closed (saturating, cleared by reset)
//   led           status LEDs
//
// Build option:
//   XILLYBUS_RD_FRAMER_LED_EN  when defined, led = {heartbeat, overflow sticky,
//                              !empty, open}. Otherwise led is tied to 4'b0.
// -----------------------------------------------------------------------------
module xillybus_rd_framer #(
  parameter int FIFO_AW = 9,
  parameter int MAX_LEN = 1024,
  parameter int HB_BITS = 26
) (
  input  logic        bus_clk,
  input  logic        rst_b,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        user_r_rden,
  output logic        user_r_empty,
  output logic [31:0] user_r_data,
  input  logic        user_r_open,
  output logic [31:0] drop_cnt,
  output logic [3:0]  led
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [15:0]        MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_TRL  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [15:0]         seq_q, seq_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                trunc_q, trunc_d;
  logic                open_q, open_d;
  // Low for the first cycle after reset release so that every output keeps
  // its reset value while rst_b is asserted, independent of user_r_open.
  logic                running_q, running_d;
  logic [31:0]         drop_q, drop_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        full;
  logic        empty;
  logic        open_rise;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic        s_ready_int;
  logic [15:0] cnt_inc;

  // Both flags come from the registered count, so a read in the same cycle
  // does not open room for a write when the FIFO is full.
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign open_rise = user_r_open && !open_q;
  assign cnt_inc   = cnt_q + 16'd1;

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    // A fresh open restarts sequence numbering; the header pushed in that
    // same cycle already carries the restarted value.
    seq_d       = open_rise ? 16'd0 : seq_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    drop_d      = drop_q;
    s_ready_int = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 32'd0;

    if (!running_q) begin
      state_d = ST_IDLE;
    end else if (!user_r_open) begin
      // Closed: abandon any partial frame, sink and count input words.
      state_d     = ST_IDLE;
      cnt_d       = 16'd0;
      trunc_d     = 1'b0;
      s_ready_int = 1'b1;
      if (s_valid && (drop_q != 32'hFFFF_FFFF)) begin
        drop_d = drop_q + 32'd1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The header goes out on the first offered word; that word itself
          // is taken in PAY on a later cycle.
          if (s_valid && !full) begin
            wr_en   = 1'b1;
            wr_data = {16'hCE7C, seq_d};
            cnt_d   = 16'd0;
            state_d = ST_PAY;
          end
        end
        ST_PAY: begin
          s_ready_int = !full;
          if (s_valid && !full) begin
            wr_en   = 1'b1;
            wr_data = s_data;
            cnt_d   = cnt_inc;
            if (s_last) begin
              trunc_d = 1'b0;
              state_d = ST_TRL;
            end else if (cnt_inc == MAX_LEN_W) begin
              // Frame is full; the rest of the packet starts a new frame.
              trunc_d = 1'b1;
              state_d = ST_TRL;
            end
          end
        end
        ST_TRL: begin
          if (!full) begin
            wr_en   = 1'b1;
            wr_data = {8'hEE, 7'b0, trunc_q, cnt_q};
            seq_d   = seq_q + 16'd1;
            cnt_d   = 16'd0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer / occupancy and read data
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_en    = running_q && user_r_open && user_r_rden && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    open_d   = user_r_open;
    running_d = 1'b1;

    if (!user_r_open) begin
      // Single-cycle flush; the last delivered word stays on user_r_data.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        rdata_d  = mem[rd_ptr_q];
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array: no reset, written only while open and not full. A write
  // and a read never touch the same entry in one cycle because reading needs
  // count>0 and writing needs count<DEPTH, and equal pointers imply 0 or DEPTH.
  always_ff @(posedge bus_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge bus_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      seq_q     <= 16'd0;
      cnt_q     <= 16'd0;
      trunc_q   <= 1'b0;
      open_q    <= 1'b0;
      running_q <= 1'b0;
      drop_q    <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      open_q    <= open_d;
      running_q <= running_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_ready      = s_ready_int;
  assign user_r_empty = empty;
  assign user_r_data  = rdata_q;
  assign drop_cnt     = drop_q;

  // ---------------------------------------------------------------------------
  // Status LEDs
  // ---------------------------------------------------------------------------
`ifdef XILLYBUS_RD_FRAMER_LED_EN
  logic [HB_BITS-1:0] hb_q, hb_d;
  logic               hb_tog_q, hb_tog_d;
  logic               sticky_q, sticky_d;

  always_comb begin
    hb_d     = hb_q + HB_BITS'(1);
    // Toggle once per full wrap of the divider: period 2^HB_BITS cycles.
    hb_tog_d = hb_tog_q ^ (hb_q == '1);
    // Overflow sticky: input was offered while the FIFO was full. A fresh
    // open clears it and wins over a same-cycle set.
    if (open_rise) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q | (s_valid && full);
    end
  end

  always_ff @(posedge bus_clk or negedge rst_b) begin
    if (!rst_b) begin
      hb_q     <= '0;
      hb_tog_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      hb_q     <= hb_d;
      hb_tog_q <= hb_tog_d;
      sticky_q <= sticky_d;
    end
  end

  assign led = running_q ? {hb_tog_q, sticky_q, !empty, user_r_open} : 4'b0;
`else
  assign led = 4'b0;
`endif

endmodule

// File: tb/tb_xillybus_rd_framer.sv
// -----------------------------------------------------------------------------
// Bench for xillybus_rd_framer with a small FIFO (8 words) and MAX_LEN=4 so
// that backpressure and truncation are reached quickly. A framing model
// pushes the expected host words into exp_q as input words are driven; a
// reader process pops and compares on every completed host read.
// -----------------------------------------------------------------------------
module tb_xillybus_rd_framer;

  localparam int FIFO_AW = 3;
  localparam int MAX_LEN = 4;
  localparam int HB_BITS = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        bus_clk;
  logic        rst_b;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        user_r_rden;
  logic        user_r_empty;
  logic [31:0] user_r_data;
  logic        user_r_open;
  logic [31:0] drop_cnt;
  logic [3:0]  led;

  xillybus_rd_framer #(
    .FIFO_AW (FIFO_AW),
    .MAX_LEN (MAX_LEN),
    .HB_BITS (HB_BITS)
  ) dut (
    .bus_clk      (bus_clk),
    .rst_b        (rst_b),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .user_r_rden  (user_r_rden),
    .user_r_empty (user_r_empty),
    .user_r_data  (user_r_data),
    .user_r_open  (user_r_open),
    .drop_cnt     (drop_cnt),
    .led          (led)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;
  int          rd_count = 0;
  int          accepted = 0;
  bit          rd_flag = 1'b0;
  bit          force_rd = 1'b0;

  // Framing model
  logic [15:0] m_seq = 16'd0;
  int          m_cnt = 0;
  bit          m_in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seq      = 16'd0;
    m_cnt      = 0;
    m_in_frame = 1'b0;
  endtask

  // Expected host words for one driven input word.
  task automatic expect_word(input logic [31:0] d, input bit last);
    if (!m_in_frame) begin
      exp_q.push_back({16'hCE7C, m_seq});
      m_in_frame = 1'b1;
      m_cnt      = 0;
    end
    exp_q.push_back(d);
    m_cnt++;
    if (last || (m_cnt == MAX_LEN)) begin
      exp_q.push_back({8'hEE, 7'd0, !last, 16'(m_cnt)});
      m_seq      = m_seq + 16'd1;
      m_in_frame = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reader: owns user_r_rden, compares each completed read
  // ---------------------------------------------------------------------------
  initial begin
    bit          pending;
    logic [31:0] e;
    pending     = 1'b0;
    user_r_rden = 1'b0;
    forever begin
      @(negedge bus_clk);
      if (pending) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected actual=%08h expected=none", user_r_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", user_r_data, e);
        end
        last_rd = user_r_data;
        rd_count++;
      end
      pending = user_r_rden && !user_r_empty && user_r_open && rst_b;
      @(posedge bus_clk);
      #1;
      user_r_rden = rd_flag ? ($urandom_range(0, 3) != 0) : force_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_word(input logic [31:0] d, input bit last);
    int t;
    bit done;
    expect_word(d, last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    t       = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge bus_clk);
      done = s_ready;
      @(posedge bus_clk);
      #1;
      t++;
      if (!done && (t >= 300)) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accept data=%08h", d);
        done = 1'b1;
      end
    end
    accepted++;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'd0;
  endtask

  task automatic send_packet(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) begin
      send_word(base + 32'(i), (i == len - 1));
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    rd_flag = 1'b1;
    t = 0;
    while (((exp_q.size() != 0) || !user_r_empty) && (t < 2000)) begin
      @(negedge bus_clk);
      t++;
    end
    rd_flag = 1'b0;
    repeat (3) @(negedge bus_clk);
    check({name, "_empty"}, 32'(user_r_empty), 32'd1);
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Table of packets
  // ---------------------------------------------------------------------------
  typedef struct {
    int          len;
    logic [31:0] base;
    bit          rd_during;
    int          exp_words;
    logic [31:0] exp_trl;
  } vec_t;

  vec_t vecs[6];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   rc0;
    int   acc0;
    int   t;
    bit   send_done;

    vecs[0] = '{3, 32'h0000_00A1, 1'b0, 5,  32'hEE00_0003};
    vecs[1] = '{6, 32'h0000_00B0, 1'b1, 10, 32'hEE00_0002};
    vecs[2] = '{4, 32'h0000_00C0, 1'b1, 6,  32'hEE00_0004};
    vecs[3] = '{1, 32'h0000_00D0, 1'b0, 3,  32'hEE00_0001};
    vecs[4] = '{8, 32'h0000_00E0, 1'b1, 12, 32'hEE00_0004};
    vecs[5] = '{2, 32'h0000_00F0, 1'b0, 4,  32'hEE00_0002};

    // Reset with the stream closed: s_ready must still read 0.
    rst_b       = 1'b0;
    s_valid     = 1'b0;
    s_data      = 32'd0;
    s_last      = 1'b0;
    user_r_open = 1'b0;
    repeat (3) @(negedge bus_clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_empty", 32'(user_r_empty), 32'd1);
    check("rst_data", user_r_data, 32'd0);
    check("rst_drop", drop_cnt, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    @(posedge bus_clk);
    #1;
    rst_b       = 1'b1;
    user_r_open = 1'b1;
    model_reset();
    cycles(3);

    // Table-driven packets
    for (int i = 0; i < 6; i++) begin
      rc0     = rd_count;
      rd_flag = vecs[i].rd_during;
      send_packet(vecs[i].len, vecs[i].base);
      wait_drain($sformatf("v%0d", i));
      check($sformatf("v%0d_words", i), 32'(rd_count - rc0), 32'(vecs[i].exp_words));
      check($sformatf("v%0d_trl", i), last_rd, vecs[i].exp_trl);
    end

    // rden while empty: nothing changes
    force_rd = 1'b1;
    repeat (5) @(negedge bus_clk);
    force_rd = 1'b0;
    cycles(2);
    check("empty_rd_hold", user_r_data, 32'hEE00_0002);
    check("empty_rd_empty", 32'(user_r_empty), 32'd1);

    // Backpressure: 20 words, no reads. 8 writes fill the FIFO:
    // hdr, 4 payload, trl, hdr, 1 payload -> 5 payload words accepted.
    rd_flag   = 1'b0;
    acc0      = accepted;
    rc0       = rd_count;
    send_done = 1'b0;
    fork
      begin
        send_packet(20, 32'h0000_0100);
        send_done = 1'b1;
      end
    join_none
    repeat (40) @(negedge bus_clk);
    check("full_accepted", 32'(accepted - acc0), 32'd5);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_not_empty", 32'(user_r_empty), 32'd0);
`ifdef XILLYBUS_RD_FRAMER_LED_EN
    check("led_open", 32'(led[0]), 32'd1);
    check("led_nempty", 32'(led[1]), 32'd1);
    check("led_sticky_set", 32'(led[2]), 32'd1);
`else
    check("led_off_full", 32'(led), 32'd0);
`endif
    rd_flag = 1'b1;
    t = 0;
    while (!send_done && (t < 3000)) begin
      @(negedge bus_clk);
      t++;
    end
    check("full_send_done", 32'(send_done), 32'd1);
    wait_drain("full");
    check("full_words", 32'(rd_count - rc0), 32'd30);

    // Closed: inputs accepted and counted, nothing queued
    @(posedge bus_clk);
    #1;
    user_r_open = 1'b0;
    cycles(2);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      @(negedge bus_clk);
      check("closed_s_ready", 32'(s_ready), 32'd1);
      @(posedge bus_clk);
      #1;
    end
    s_valid = 1'b0;
    @(negedge bus_clk);
    check("closed_drop", drop_cnt, 32'd5);
    check("closed_empty", 32'(user_r_empty), 32'd1);
    @(posedge bus_clk);
    #1;
    user_r_open = 1'b1;
    model_reset();
    cycles(2);
`ifdef XILLYBUS_RD_FRAMER_LED_EN
    check("led_sticky_clr", 32'(led[2]), 32'd0);
`endif
    rc0 = rd_count;
    send_packet(1, 32'h0000_0055);
    wait_drain("reopen");
    check("reopen_words", 32'(rd_count - rc0), 32'd3);
    check("reopen_drop_held", drop_cnt, 32'd5);

    // Close mid-frame with 6 words unread
    send_packet(1, 32'h0000_0060);
    send_word(32'h0000_0061, 1'b0);
    send_word(32'h0000_0062, 1'b0);
    @(negedge bus_clk);
    check("mid_not_empty", 32'(user_r_empty), 32'd0);
    @(posedge bus_clk);
    #1;
    user_r_open = 1'b0;
    @(negedge bus_clk);
    check("mid_empty_before_edge", 32'(user_r_empty), 32'd0);
    @(negedge bus_clk);
    check("mid_flush_empty", 32'(user_r_empty), 32'd1);
    cycles(1);
    user_r_open = 1'b1;
    model_reset();
    cycles(2);
    rc0 = rd_count;
    send_packet(2, 32'h0000_0070);
    wait_drain("mid_reopen");
    check("mid_reopen_words", 32'(rd_count - rc0), 32'd4);
    check("mid_reopen_trl", last_rd, 32'hEE00_0002);
    check("mid_drop_same", drop_cnt, 32'd5);

`ifdef XILLYBUS_RD_FRAMER_LED_EN
    // Heartbeat period
    begin
      logic prev;
      int   n;
      @(negedge bus_clk);
      prev = led[3];
      t = 0;
      while ((led[3] == prev) && (t < 100)) begin
        @(negedge bus_clk);
        t++;
      end
      prev = led[3];
      n = 0;
      while ((led[3] == prev) && (n < 100)) begin
        @(negedge bus_clk);
        n++;
      end
      check("hb_period", 32'(n), 32'd16);
    end
`else
    check("led_off_end", 32'(led), 32'd0);
`endif

    // Asynchronous reset in the middle of a frame
    send_word(32'h0000_0080, 1'b0);
    @(negedge bus_clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_empty", 32'(user_r_empty), 32'd1);
    check("arst_s_ready", 32'(s_ready), 32'd0);
    check("arst_data", user_r_data, 32'd0);
    check("arst_drop", drop_cnt, 32'd0);
    check("arst_led", 32'(led), 32'd0);
    model_reset();
    @(posedge bus_clk);
    #1;
    rst_b = 1'b1;
    cycles(3);
    rc0 = rd_count;
    send_packet(1, 32'h0000_0090);
    wait_drain("post_rst");
    check("post_rst_words", 32'(rd_count - rc0), 32'd3);
    check("post_rst_trl", last_rd, 32'hEE00_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
